cla_32: RTL and testbench

CLA_32 -- requirements
Module: cla_32

---
 rtl/cla_32.sv | 71 +++++++
 tb/tb_cla_32.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cla_32.sv
// 32-bit two-level carry-lookahead adder with a registered sum and carry out.
// Eight 4-bit groups feed two 4-group lookahead blocks, which feed a top carry unit.
module cla_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);

  // Carries into positions 0..3 of a 4-wide lookahead slice; position 0 is ci.
  function automatic logic [3:0] la_carries(input logic [3:0] pp, input logic [3:0] gg,
                                            input logic ci);
    logic [3:0] cc;
    cc[0] = ci;
    cc[1] = gg[0] | (pp[0] & ci);
    cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
    return cc;
  endfunction

  function automatic logic la_gen(input logic [3:0] pp, input logic [3:0] gg);
    return gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
  endfunction

  logic [31:0] p, g, c_bit, sum;
  logic [7:0]  grp_p, grp_g, grp_c;
  logic [3:0]  grp_c_lo, grp_c_hi;
  logic [1:0]  blk_p, blk_g;
  logic        c16, c32;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar k = 0; k < 8; k++) begin : g_grp_pg
    assign grp_p[k] = &p[4*k +: 4];
    assign grp_g[k] = la_gen(p[4*k +: 4], g[4*k +: 4]);
  end

  for (genvar j = 0; j < 2; j++) begin : g_blk_pg
    assign blk_p[j] = &grp_p[4*j +: 4];
    assign blk_g[j] = la_gen(grp_p[4*j +: 4], grp_g[4*j +: 4]);
  end

  // Top unit: both block carries come straight from c_in, never through each other.
  assign c16 = blk_g[0] | (blk_p[0] & c_in);
  assign c32 = blk_g[1] | (blk_p[1] & blk_g[0]) | (blk_p[1] & blk_p[0] & c_in);

  assign grp_c_lo = la_carries(grp_p[3:0], grp_g[3:0], c_in);
  assign grp_c_hi = la_carries(grp_p[7:4], grp_g[7:4], c16);
  assign grp_c    = {grp_c_hi, grp_c_lo};

  for (genvar k = 0; k < 8; k++) begin : g_grp_c
    assign c_bit[4*k +: 4] = la_carries(p[4*k +: 4], g[4*k +: 4], grp_c[k]);
  end

  assign sum = p ^ c_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s     <= 32'h0;
      c_out <= 1'b0;
    end else begin
      s     <= sum;
      c_out <= c32;
    end
  end

endmodule

// File: tb/tb_cla_32.sv
// Self-checking bench for cla_32: directed boundary cases, reset behaviour,
// and random operands against a plain-arithmetic reference.
module tb_cla_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        c_in;
  logic [31:0] s;
  logic        c_out;

  int tests_run = 0;
  int fails     = 0;

  cla_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .s     (s),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'h0, ci};
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive operands away from the rising edge, then sample just after it.
  task automatic step(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
    @(negedge clk);
    a    = ta;
    b    = tb;
    c_in = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tc);
    step(ta, tb, tc);
    chk(tag, {c_out, s}, ref_sum(ta, tb, tc));
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] held;

    rst_n = 1'b0;
    a = 32'h0; b = 32'h0; c_in = 1'b0;
    #1;
    chk("reset_state", {c_out, s}, 33'h0);

    // Reset must hold the outputs at zero across clock edges.
    step(32'h5, 32'h7, 1'b1);
    chk("reset_hold", {c_out, s}, 33'h0);

    // First edge after release loads the inputs present then.
    @(negedge clk);
    a = 32'h3; b = 32'h4; c_in = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_after_reset", {c_out, s}, {1'b0, 32'h8});

    step(32'h0, 32'h0, 1'b0);
    chk("zero", {c_out, s}, {1'b0, 32'h0});
    step(32'h1, 32'h0, 1'b0);
    chk("a_one", {c_out, s}, {1'b0, 32'h1});
    step(32'h0, 32'h0, 1'b1);
    chk("cin_one", {c_out, s}, {1'b0, 32'h1});

    for (int k = 0; k < 8; k++) begin
      step(32'h1 << (4*k), 32'h0, 1'b0);
      chk($sformatf("grp_a_%0d", k), {c_out, s}, {1'b0, 32'h1 << (4*k)});
      step(32'h0, 32'h1 << (4*k), 1'b0);
      chk($sformatf("grp_b_%0d", k), {c_out, s}, {1'b0, 32'h1 << (4*k)});
    end

    for (int k = 0; k < 7; k++) begin
      step(32'h1 << (4*k+3), 32'h1 << (4*k+3), 1'b0);
      chk($sformatf("grp_carry_%0d", k), {c_out, s}, {1'b0, 32'h1 << (4*k+4)});
    end

    step(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("msb_carry", {c_out, s}, {1'b1, 32'h0});
    step(32'hFFFF_FFFF, 32'h0, 1'b1);
    chk("full_propagate", {c_out, s}, {1'b1, 32'h0});
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("all_ones_both", {c_out, s}, {1'b1, 32'hFFFF_FFFF});
    step_chk("alt_pattern", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);

    // Inputs changing between edges must not reach the outputs early.
    step(32'h1234_5678, 32'h1111_1111, 1'b0);
    held = {c_out, s};
    chk("hold_before", held, {1'b0, 32'h2345_6789});
    #2;
    a = 32'hDEAD_BEEF; b = 32'h0F0F_0F0F; c_in = 1'b1;
    #2;
    chk("hold_between_edges", {c_out, s}, held);
    @(posedge clk);
    #1;
    chk("hold_after_edge", {c_out, s}, ref_sum(32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b1));

    // Mid-operation reset clears immediately and discards the pending sum.
    step(32'h0000_0123, 32'h0000_0456, 1'b0);
    chk("pre_reset_nonzero", {c_out, s}, {1'b0, 32'h0000_0579});
    @(negedge clk);
    a = 32'hFFFF_0000; b = 32'h0001_0000; c_in = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {c_out, s}, 33'h0);
    @(posedge clk);
    #1;
    chk("reset_discard", {c_out, s}, 33'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_load", {c_out, s}, {1'b1, 32'h0});

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      step_chk("random", ra, rb, rc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
